fdiv_arbiter: RTL and testbench

FDIV_ARBITER -- requirements
Module: fdiv_arbiter

---
 rtl/fdiv_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fdiv_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_arbiter.sv
// rtl/fdiv_arbiter.sv - two-requester round-robin arbiter sharing one single-precision divider
// fdiv is a combinational IEEE single divider (truncating, denormals flushed to zero).

module fdiv (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf
);
    logic              sa, sb, s;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0]       num;
    logic [24:0]       q;
    logic [22:0]       mant;
    logic signed [9:0] e;

    assign sa = x1[31];
    assign sb = x2[31];
    assign ea = x1[30:23];
    assign eb = x2[30:23];
    assign fa = x1[22:0];
    assign fb = x2[22:0];
    assign s  = sa ^ sb;

    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);

    // Quotient of the 1.f mantissas scaled by 2^24 lies in [2^23, 2^25).
    assign num = {1'b1, fa, 24'd0};
    assign q   = 25'(num / {24'd0, 1'b1, fb});

    always_comb begin
        y    = 32'd0;
        ovf  = 1'b0;
        mant = q[24] ? q[23:1] : q[22:0];
        e    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (!q[24]) begin
            e = e - 10'sd1;
        end
        if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
            y = 32'h7FC0_0000;
        end else if (inf_a || zero_b) begin
            y = {s, 8'hFF, 23'd0};
        end else if (zero_a || inf_b) begin
            y = {s, 31'd0};
        end else if (e >= 10'sd255) begin
            y   = {s, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            y = {s, 31'd0};
        end else begin
            y = {s, e[7:0], mant};
        end
    end
endmodule

module fdiv_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_y,
    output logic        resp0_ovf,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_y,
    output logic        resp1_ovf,
    input  logic        resp1_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        owner;
    logic [31:0] op_x1, op_x2;
    logic [31:0] res_y;
    logic        res_ovf;
    logic [31:0] fd_y;
    logic        fd_ovf;
    logic        grant0, grant1;

    fdiv u_fdiv (
        .x1  (op_x1),
        .x2  (op_x2),
        .y   (fd_y),
        .ovf (fd_ovf)
    );

    // On a tie the requester that did not win last time gets the grant.
    assign grant0     = req0_valid && (!req1_valid || last_grant);
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = rstn && (state == IDLE) && grant0;
    assign req1_ready = rstn && (state == IDLE) && grant1;

    assign resp0_valid = (state == DONE) && !owner;
    assign resp1_valid = (state == DONE) && owner;
    assign resp0_y     = res_y;
    assign resp1_y     = res_y;
    assign resp0_ovf   = res_ovf;
    assign resp1_ovf   = res_ovf;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_x1      <= 32'd0;
            op_x2      <= 32'd0;
            res_y      <= 32'd0;
            res_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid && req0_ready) begin
                        op_x1      <= req0_x1;
                        op_x2      <= req0_x2;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= BUSY;
                    end else if (req1_valid && req1_ready) begin
                        op_x1      <= req1_x1;
                        op_x2      <= req1_x2;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_y   <= fd_y;
                        res_ovf <= fd_ovf;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if ((!owner && resp0_ready) || (owner && resp1_ready)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv_arbiter.sv
// tb/tb_fdiv_arbiter.sv - scoreboard and vector-table bench for fdiv_arbiter

module tb_fdiv_arbiter;
    localparam int LAT = 4;

    logic        clk, rstn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x1, req0_x2, req1_x1, req1_x2;
    logic        resp0_valid, resp0_ovf, resp0_ready;
    logic        resp1_valid, resp1_ovf, resp1_ready;
    logic [31:0] resp0_y, resp1_y;
    logic        busy;

    fdiv_arbiter #(.LATENCY(LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req0_valid  (req0_valid),
        .req0_x1     (req0_x1),
        .req0_x2     (req0_x2),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_x1     (req1_x1),
        .req1_x2     (req1_x2),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_y     (resp0_y),
        .resp0_ovf   (resp0_ovf),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_y     (resp1_y),
        .resp1_ovf   (resp1_ovf),
        .resp1_ready (resp1_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic [31:0] y;
        logic        ovf;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    exp_t        sb[$];
    int          gq[$];
    vec_t        vt[8];
    int          cyc, n_tests, n_fail;
    logic        seen;
    logic        s_busy, s_rv0, s_rv1, s_rd0, s_rd1, s_o0, s_o1, acc0, acc1;
    logic [31:0] s_y0, s_y1;
    logic [31:0] nx0_y, nx1_y;
    logic        nx0_o, nx1_o;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_resp(input logic w, input logic v, input logic r,
                              input logic [31:0] y, input logic o);
        if (v) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp%0d_unexpected: got valid=1 expected no response (cycle %0d)", w, cyc);
            end else begin
                if (!seen) begin
                    chk("resp_owner", {31'd0, w}, {31'd0, sb[0].who});
                    chk("resp_latency", cyc, sb[0].due);
                    seen = 1'b1;
                end
                if (r) begin
                    chk("resp_y", y, sb[0].y);
                    chk("resp_ovf", {31'd0, o}, {31'd0, sb[0].ovf});
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    endtask

    // Sample everything on the falling edge, then advance one rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        s_busy = busy;  s_rv0 = resp0_valid; s_rv1 = resp1_valid;
        s_rd0 = req0_ready; s_rd1 = req1_ready;
        s_y0 = resp0_y; s_y1 = resp1_y; s_o0 = resp0_ovf; s_o1 = resp1_ovf;
        acc0 = rstn && req0_valid && req0_ready;
        acc1 = rstn && req1_valid && req1_ready;
        if (!rstn) begin
            chk("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
            sb.delete();
            seen = 1'b0;
        end else begin
            chk("ready_onehot", {31'd0, req0_ready && req1_ready}, 32'd0);
            check_resp(1'b0, resp0_valid, resp0_ready, resp0_y, resp0_ovf);
            check_resp(1'b1, resp1_valid, resp1_ready, resp1_y, resp1_ovf);
            if (acc0) begin
                e = '{who: 1'b0, y: nx0_y, ovf: nx0_o, due: cyc + LAT + 1};
                sb.push_back(e);
                gq.push_back(0);
            end
            if (acc1) begin
                e = '{who: 1'b1, y: nx1_y, ovf: nx1_o, due: cyc + LAT + 1};
                sb.push_back(e);
                gq.push_back(1);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || s_busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", {31'd0, n < budget}, 32'd1);
    endtask

    task automatic run_vec(input logic w, input vec_t v);
        if (!w) begin
            req0_valid = 1'b1; req0_x1 = v.x1; req0_x2 = v.x2; nx0_y = v.y; nx0_o = v.ovf;
        end else begin
            req1_valid = 1'b1; req1_x1 = v.x1; req1_x2 = v.x2; nx1_y = v.y; nx1_o = v.ovf;
        end
        tick();
        chk("vec_accept", {31'd0, w ? acc1 : acc0}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            chk("vec_busy", {31'd0, s_busy}, 32'd1);
            chk("vec_no_resp", {30'd0, s_rv0, s_rv1}, 32'd0);
        end
        tick();
        chk("vec_resp_valid", {30'd0, s_rv0, s_rv1}, w ? 32'd1 : 32'd2);
        tick();
        chk("vec_idle_after", {31'd0, s_busy}, 32'd0);
        chk("vec_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        vt[0] = '{x1: 32'h3F800000, x2: 32'h40000000, y: 32'h3F000000, ovf: 1'b0};
        vt[1] = '{x1: 32'h40C00000, x2: 32'h40400000, y: 32'h40000000, ovf: 1'b0};
        vt[2] = '{x1: 32'h7F000000, x2: 32'h00800000, y: 32'h7F800000, ovf: 1'b1};
        vt[3] = '{x1: 32'h3F800000, x2: 32'h3F800000, y: 32'h3F800000, ovf: 1'b0};
        vt[4] = '{x1: 32'hC1000000, x2: 32'h40000000, y: 32'hC0800000, ovf: 1'b0};
        vt[5] = '{x1: 32'h40400000, x2: 32'h3FC00000, y: 32'h40000000, ovf: 1'b0};
        vt[6] = '{x1: 32'h00000000, x2: 32'h40000000, y: 32'h00000000, ovf: 1'b0};
        vt[7] = '{x1: 32'h3FC00000, x2: 32'h40400000, y: 32'h3F000000, ovf: 1'b0};

        cyc = 0; n_tests = 0; n_fail = 0; seen = 1'b0;
        s_busy = 1'b0;
        rstn = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        // Both requesters already valid while reset is held: tie on release.
        req0_valid = 1'b1; req0_x1 = 32'h40C00000; req0_x2 = 32'h40400000;
        req1_valid = 1'b1; req1_x1 = 32'h3F800000; req1_x2 = 32'h40000000;
        nx0_y = 32'h40000000; nx0_o = 1'b0;
        nx1_y = 32'h3F000000; nx1_o = 1'b0;
        tick();
        tick();
        chk("reset_busy", {31'd0, s_busy}, 32'd0);
        chk("reset_resp_valid", {30'd0, s_rv0, s_rv1}, 32'd0);
        chk("reset_y0", s_y0, 32'd0);
        chk("reset_y1", s_y1, 32'd0);

        rstn = 1'b1;
        gq.delete();
        tick();
        chk("first_cycle_accept_req0", {30'd0, acc0, acc1}, 32'd2);
        for (int n = 0; n < 60 && gq.size() < 4; n++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("tie_grant_count", gq.size(), 32'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("tie_grant_order", gq[i], i % 2);
        wait_idle(40);

        for (int i = 0; i < 8; i++) run_vec(1'(i % 2), vt[i]);

        // Back-pressure on requester 1 with both requesters hammering.
        resp1_ready = 1'b0;
        req1_valid = 1'b1; req1_x1 = 32'h40400000; req1_x2 = 32'h3FC00000;
        nx1_y = 32'h40000000; nx1_o = 1'b0;
        tick();
        req1_valid = 1'b0;
        for (int n = 0; n < 20 && !s_rv1; n++) tick();
        chk("bp_resp_seen", {31'd0, s_rv1}, 32'd1);
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h3F800000;
        nx0_y = 32'h3F800000; nx0_o = 1'b0;
        req1_valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            req1_x1 = $urandom; req1_x2 = $urandom;
            tick();
            chk("bp_valid_held", {30'd0, s_rv0, s_rv1}, 32'd1);
            chk("bp_y_held", s_y1, 32'h40000000);
            chk("bp_ovf_held", {31'd0, s_o1}, 32'd0);
            chk("bp_readies_low", {30'd0, s_rd0, s_rd1}, 32'd0);
            chk("bp_busy", {31'd0, s_busy}, 32'd1);
        end
        req1_valid = 1'b0;
        resp1_ready = 1'b1;
        tick();
        chk("bp_no_accept_in_done", {30'd0, acc0, acc1}, 32'd0);
        tick();
        chk("bp_idle_next", {31'd0, s_busy}, 32'd0);
        chk("bp_accept_after_idle", {31'd0, acc0}, 32'd1);
        req0_valid = 1'b0;
        wait_idle(40);

        // Operands scrambled while the operation is in flight.
        req0_valid = 1'b1; req0_x1 = 32'h3F800000; req0_x2 = 32'h40000000;
        nx0_y = 32'h3F000000; nx0_o = 1'b0;
        tick();
        chk("iso_accept", {31'd0, acc0}, 32'd1);
        req0_valid = 1'b0;
        for (int n = 0; n < 20 && (s_busy || sb.size() != 0); n++) begin
            req0_x1 = $urandom; req0_x2 = $urandom;
            tick();
        end
        chk("iso_sb_empty", sb.size(), 32'd0);
        wait_idle(20);

        // Reset two cycles after accept discards the operation.
        req1_valid = 1'b1; req1_x1 = 32'hC1000000; req1_x2 = 32'h40000000;
        nx1_y = 32'hC0800000; nx1_o = 1'b0;
        tick();
        chk("rst_mid_accept", {31'd0, acc1}, 32'd1);
        req1_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            chk("rst_mid_no_resp", {30'd0, s_rv0, s_rv1}, 32'd0);
        end
        run_vec(1'b0, vt[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
